// File: rtl/keypad_divider_seq.sv
// Keypad operand entry (NIB hex nibbles per operand, MSB first) followed by a restoring divider
// that produces one quotient bit per clock. Optional build macro: KEY_EDGE_DETECT_EN.
module keypad_divider_seq #(
  parameter int unsigned NIB = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_hex,
  input  logic                 clear,
  output logic [1:0]           phase,
  output logic [4*NIB-1:0]     a_val,
  output logic [4*NIB-1:0]     b_val,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIB-1:0]     quotient,
  output logic [4*NIB-1:0]     remainder,
  output logic                 div_zero
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned IW = $clog2(W);

  localparam logic [1:0] ENTRY_A = 2'd0;
  localparam logic [1:0] ENTRY_B = 2'd1;
  localparam logic [1:0] DIVIDE  = 2'd2;
  localparam logic [1:0] RESULT  = 2'd3;

  logic          key_stb;
  logic [3:0]    key_dat;

`ifdef KEY_EDGE_DETECT_EN
  // A key counts once when key_hex differs from the previous clock; history survives clear.
  logic [3:0] last_hex;
  logic       stb_r;
  logic       unused_key_valid;

  assign unused_key_valid = key_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_hex <= 4'hF;
      stb_r    <= 1'b0;
    end else begin
      last_hex <= key_hex;
      stb_r    <= (key_hex != last_hex);
    end
  end

  assign key_stb = stb_r;
  assign key_dat = last_hex;
`else
  assign key_stb = key_valid;
  assign key_dat = key_hex;
`endif

  logic [1:0]    phase_d;
  logic [W-1:0]  a_d, b_d, quo_out_d, rem_out_d;
  logic          busy_d, done_d, dz_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] iter, iter_d;
  logic [W-1:0]  rem_r, rem_d;
  logic [W-1:0]  quo_r, quo_d;

  // Restoring step datapath: shifted partial remainder is W+1 bits wide.
  logic [IW-1:0] a_idx;
  logic [W:0]    step_r, diff;
  logic          ge;
  logic [W-1:0]  step_n;

  assign a_idx  = IW'(W - 1) - iter;
  assign step_r = {rem_r, a_val[a_idx]};
  assign diff   = step_r - {1'b0, b_val};
  assign ge     = ~diff[W];
  assign step_n = ge ? diff[W-1:0] : step_r[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= ENTRY_A;
      a_val     <= '0;
      b_val     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      iter      <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
    end else begin
      phase     <= phase_d;
      a_val     <= a_d;
      b_val     <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      quotient  <= quo_out_d;
      remainder <= rem_out_d;
      div_zero  <= dz_d;
      cnt       <= cnt_d;
      iter      <= iter_d;
      rem_r     <= rem_d;
      quo_r     <= quo_d;
    end
  end

  always_comb begin
    phase_d   = phase;
    a_d       = a_val;
    b_d       = b_val;
    busy_d    = busy;
    done_d    = 1'b0;
    quo_out_d = quotient;
    rem_out_d = remainder;
    dz_d      = div_zero;
    cnt_d     = cnt;
    iter_d    = iter;
    rem_d     = rem_r;
    quo_d     = quo_r;

    if (clear) begin
      phase_d   = ENTRY_A;
      a_d       = '0;
      b_d       = '0;
      busy_d    = 1'b0;
      quo_out_d = '0;
      rem_out_d = '0;
      dz_d      = 1'b0;
      cnt_d     = '0;
      iter_d    = '0;
      rem_d     = '0;
      quo_d     = '0;
    end else begin
      case (phase)
        ENTRY_A, ENTRY_B: begin
          if (key_stb) begin
            if (phase == ENTRY_A) a_d = W'({a_val, key_dat});
            else                  b_d = W'({b_val, key_dat});
            if (cnt == CW'(NIB - 1)) begin
              cnt_d = '0;
              if (phase == ENTRY_A) begin
                phase_d = ENTRY_B;
              end else begin
                phase_d = DIVIDE;
                busy_d  = 1'b1;
                iter_d  = '0;
                rem_d   = '0;
                quo_d   = '0;
              end
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
        end
        DIVIDE: begin
          if (iter == '0 && b_val == '0) begin
            phase_d   = RESULT;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            quo_out_d = '0;
            rem_out_d = a_val;
            dz_d      = 1'b1;
          end else begin
            rem_d  = step_n;
            quo_d  = W'({quo_r, ge});
            iter_d = iter + IW'(1);
            if (iter == IW'(W - 1)) begin
              phase_d   = RESULT;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              quo_out_d = W'({quo_r, ge});
              rem_out_d = step_n;
              dz_d      = 1'b0;
            end
          end
        end
        default: begin
          // RESULT: a key opens a fresh entry with that key as the first A nibble.
          if (key_stb) begin
            a_d  = W'(key_dat);
            b_d  = '0;
            dz_d = 1'b0;
            if (NIB == 1) begin
              phase_d = ENTRY_B;
              cnt_d   = '0;
            end else begin
              phase_d = ENTRY_A;
              cnt_d   = CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_divider_seq.sv
// Self-checking bench for keypad_divider_seq (NIB=2): vector table plus a done-time scoreboard.
module tb_keypad_divider_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, key_valid, clear;
  logic [3:0]   key_hex;
  logic [1:0]   phase;
  logic [W-1:0] a_val, b_val, quotient, remainder;
  logic         busy, done, div_zero;

  keypad_divider_seq #(.NIB(2)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_hex(key_hex), .clear(clear),
    .phase(phase), .a_val(a_val), .b_val(b_val), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz;
  } vec_t;

  typedef struct {
    logic [7:0]  q, r;
    logic        dz;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any completed divide against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient",     32'(quotient),  32'(e.q));
        chk("remainder",    32'(remainder), 32'(e.r));
        chk("div_zero",     32'(div_zero),  32'(e.dz));
        chk("done_latency", 32'(cyc),       32'(e.due));
      end
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_hex   = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter(input vec_t v, input bit push);
    exp_t e;
    press(v.a[7:4]);
    press(v.a[3:0]);
    press(v.b[7:4]);
    press(v.b[3:0]);
    if (push) begin
      e.q   = v.q;
      e.r   = v.r;
      e.dz  = v.dz;
      e.due = cyc + (v.dz ? 1 : W);
      sb.push_back(e);
    end
  endtask

  task automatic wait_sb(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  vec_t tv[8];
  vec_t v;

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    key_valid = 1'b0;
`ifdef KEY_EDGE_DETECT_EN
    key_hex   = 4'hF;
`else
    key_hex   = 4'h0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_a",     32'(a_val), 32'd0);
    chk("rst_b",     32'(b_val), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_q",     32'(quotient),  32'd0);
    chk("rst_r",     32'(remainder), 32'd0);
    chk("rst_dz",    32'(div_zero),  32'd0);

`ifdef KEY_EDGE_DETECT_EN
    key_hex = 4'h3;
    for (int i = 0; i < 20; i++) begin
      key_valid = i[0];
      tick();
    end
    key_valid = 1'b0;
    chk("ed_hold_a",     32'(a_val), 32'h03);
    chk("ed_hold_phase", 32'(phase), 32'd0);
    key_hex = 4'h5;
    tick();
    chk("ed_latency_a", 32'(a_val), 32'h03);
    tick();
    chk("ed_second_a",  32'(a_val), 32'h35);
    chk("ed_phase_b",   32'(phase), 32'd1);
`else
    tv[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
    tv[2] = '{8'h05, 8'h09, 8'h00, 8'h05, 1'b0};
    tv[3] = '{8'hC8, 8'hC8, 8'h01, 8'h00, 1'b0};
    tv[4] = '{8'h00, 8'h03, 8'h00, 8'h00, 1'b0};
    for (int i = 5; i < 7; i++) begin
      tv[i].a  = 8'($urandom_range(0, 255));
      tv[i].b  = 8'($urandom_range(1, 255));
      tv[i].q  = tv[i].a / tv[i].b;
      tv[i].r  = tv[i].a % tv[i].b;
      tv[i].dz = 1'b0;
    end
    tv[7] = '{8'h2A, 8'h00, 8'h00, 8'h2A, 1'b1};

    for (int i = 0; i < 8; i++) begin
      enter(tv[i], 1'b1);
      chk("vec_a",          32'(a_val), 32'(tv[i].a));
      chk("vec_b",          32'(b_val), 32'(tv[i].b));
      chk("vec_phase_div",  32'(phase), 32'd2);
      chk("vec_busy_start", 32'(busy),  32'd1);
      tick();
      chk("vec_busy_next",  32'(busy),  32'(tv[i].b != 8'h00));
      wait_sb(12);
      chk("vec_phase_res",  32'(phase), 32'd3);
      tick();
      chk("vec_done_pulse", 32'(done),  32'd0);
    end

    // New entry from RESULT after a divide-by-zero: flag drops, results held.
    press(4'h9);
    chk("new_phase", 32'(phase),     32'd0);
    chk("new_a",     32'(a_val),     32'h09);
    chk("new_b",     32'(b_val),     32'h00);
    chk("new_dz",    32'(div_zero),  32'd0);
    chk("new_q",     32'(quotient),  32'h00);
    chk("new_r",     32'(remainder), 32'h2A);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_phase", 32'(phase), 32'd0);
    chk("clr_a",     32'(a_val), 32'd0);

    // Keys arriving mid-divide must not disturb operands or the result.
    v = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};
    enter(v, 1'b1);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    wait_sb(12);
    chk("ign_a", 32'(a_val), 32'h64);
    chk("ign_b", 32'(b_val), 32'h07);

    // Abort mid-divide with a simultaneous key: no done, key lost, everything zeroed.
    enter(v, 1'b0);
    repeat (4) tick();
    clear     = 1'b1;
    key_valid = 1'b1;
    key_hex   = 4'h5;
    tick();
    clear     = 1'b0;
    key_valid = 1'b0;
    chk("abort_phase", 32'(phase),     32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_a",     32'(a_val),     32'd0);
    chk("abort_b",     32'(b_val),     32'd0);
    chk("abort_q",     32'(quotient),  32'd0);
    chk("abort_r",     32'(remainder), 32'd0);
    repeat (12) tick();
    chk("abort_idle_phase", 32'(phase), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
